mul_arbiter: RTL and testbench

- Round-robin arbiter that shares one 1-cycle fixed-point multiplier (`multiplication`) among NUM_REQ requesters, for example shader lanes and ray/box units.
- Accepts at most one operand pair per cycle, tags it with the requester index, and routes the result back to that requester.
- Each requester has a response holding register with valid/ready backpressure.
- Sits between the compute units and the shared multiplier in the math datapath.

---
 rtl/mul_arbiter_pkg.sv | 12 +
 rtl/mul_arbiter_if.sv | 30 +++
 rtl/mul_arbiter_rr_picker.sv | 32 +++
 rtl/multiplication.sv | 41 ++++
 rtl/mul_arbiter.sv | 114 +++++++++++
 tb/tb_mul_arbiter.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/mul_arbiter_pkg.sv
// rtl/mul_arbiter_pkg.sv - shared widths and types for the multiplier arbiter
package mul_arbiter_pkg;

   // Default fixed-point format: Q16.16 in a 32-bit word
   localparam int WIDTH_DEF   = 32;
   localparam int Q_BITS_DEF  = 16;
   localparam int NUM_REQ_DEF = 4;

   typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_idx_t;
   typedef logic signed [WIDTH_DEF-1:0]     fix_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - requester-side bundle of the shared multiplier arbiter
interface mul_arbiter_if
   import mul_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int WIDTH   = WIDTH_DEF
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            resp_valid;
   logic [NUM_REQ-1:0][WIDTH-1:0] resp_result;
   logic [NUM_REQ-1:0]            resp_ready;
   logic                          idle;

   // Compute units drive operands and consume results
   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_result, idle
   );

   // The arbiter grants operands and returns results
   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_result, idle
   );

endinterface

// File: rtl/mul_arbiter_rr_picker.sv
// rtl/mul_arbiter_rr_picker.sv - round-robin one-hot picker starting at a pointer
module mul_arbiter_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     eligible_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   // Scan offsets from far to near so the nearest eligible slot to ptr wins last
   always_comb begin
      int j;
      j       = 0;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int off = N - 1; off >= 0; off--) begin
         j = int'(ptr_i) + off;
         if (j >= N) j = j - N;
         if (eligible_i[IDX_W'(j)]) begin
            grant_o                = '0;
            grant_o[IDX_W'(j)]     = 1'b1;
            idx_o                  = IDX_W'(j);
            any_o                  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multiplication.sv
// rtl/multiplication.sv - one-cycle signed fixed-point multiplier, truncating and wrapping
module multiplication
   import mul_arbiter_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int Q_BITS = Q_BITS_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] product_o,
   output logic             valid_o
);

   logic signed [2*WIDTH-1:0] full_prod;
   logic [WIDTH-1:0]          product_d;
   logic [WIDTH-1:0]          product_q;
   logic                      valid_q;

   // Sign-extend both operands so the low 2*WIDTH bits are the exact product
   assign full_prod = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) *
                      $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
   assign product_d = WIDTH'(full_prod >>> Q_BITS);

   // Capture the Q-aligned product one edge after start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         product_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         valid_q <= start_i;
         if (start_i) product_q <= product_d;
      end
   end

   assign product_o = product_q;
   assign valid_o   = valid_q;

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin sharing of one multiplier among NUM_REQ requesters
module mul_arbiter
   import mul_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int Q_BITS  = Q_BITS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   mul_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic                          inflight_vld_q, inflight_vld_d;
   logic [IDX_W-1:0]              inflight_tag_q, inflight_tag_d;
   logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]            resp_valid_q, resp_valid_d;
   logic [NUM_REQ-1:0][WIDTH-1:0] resp_result_q, resp_result_d;

   logic [NUM_REQ-1:0]            eligible;
   logic [NUM_REQ-1:0]            grant;
   logic [IDX_W-1:0]              gnt_idx;
   logic                          gnt_any;
   logic [WIDTH-1:0]              mul_a, mul_b, mul_product;
   logic                          mul_valid;
   logic                          wb;

   // A requester may issue only if nothing of its own is in flight and its
   // holding slot is free or being drained this cycle; nothing is granted in reset
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = bus.req_valid[i]
                     & ~(inflight_vld_q && (inflight_tag_q == IDX_W'(i)))
                     & (~resp_valid_q[i] | bus.resp_ready[i]);
      end
      if (rst) eligible = '0;
   end

   mul_arbiter_rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .eligible_i (eligible),
      .ptr_i      (rr_ptr_q),
      .grant_o    (grant),
      .idx_o      (gnt_idx),
      .any_o      (gnt_any)
   );

   assign mul_a = bus.req_a[gnt_idx];
   assign mul_b = bus.req_b[gnt_idx];

   multiplication #(
      .WIDTH  (WIDTH),
      .Q_BITS (Q_BITS)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (gnt_any),
      .a_i       (mul_a),
      .b_i       (mul_b),
      .product_o (mul_product),
      .valid_o   (mul_valid)
   );

   // Multiplier output only counts when our own in-flight record agrees
   assign wb = inflight_vld_q & mul_valid;

   // Next state: issue bookkeeping, pointer advance, pop then writeback per slot
   always_comb begin
      inflight_vld_d = gnt_any;
      inflight_tag_d = inflight_tag_q;
      rr_ptr_d       = rr_ptr_q;
      resp_valid_d   = resp_valid_q;
      resp_result_d  = resp_result_q;
      if (gnt_any) begin
         inflight_tag_d = gnt_idx;
         rr_ptr_d       = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (resp_valid_q[i] && bus.resp_ready[i]) resp_valid_d[i] = 1'b0;
         if (wb && (inflight_tag_q == IDX_W'(i))) begin
            resp_valid_d[i]  = 1'b1;
            resp_result_d[i] = mul_product;
         end
      end
   end

   // State registers, cleared asynchronously so reset drops results at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_vld_q <= 1'b0;
         inflight_tag_q <= '0;
         rr_ptr_q       <= '0;
         resp_valid_q   <= '0;
         resp_result_q  <= '0;
      end else begin
         inflight_vld_q <= inflight_vld_d;
         inflight_tag_q <= inflight_tag_d;
         rr_ptr_q       <= rr_ptr_d;
         resp_valid_q   <= resp_valid_d;
         resp_result_q  <= resp_result_d;
      end
   end

   assign bus.req_ready   = grant;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = resp_result_q;
   assign bus.idle        = ~inflight_vld_q & ~(|resp_valid_q);

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - randomized and directed bench for mul_arbiter against a cycle model
module tb_mul_arbiter;
   import mul_arbiter_pkg::*;

   localparam int N = 4;
   localparam int W = 32;
   localparam int Q = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mul_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

   mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .Q_BITS(Q)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference state: rotation pointer, the one tagged operation in the
   // multiplier (-1 when none) and each requester's held result
   int         m_ptr;
   int         m_tag;
   logic [W-1:0] m_prod;
   bit         m_rv  [N];
   logic [W-1:0] m_res [N];
   logic [N-1:0] last_ready;

   function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return p[47:16];
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      m_tag = -1;
      m_prod = '0;
      for (int i = 0; i < N; i++) begin
         m_rv[i]  = 1'b0;
         m_res[i] = '0;
      end
   endtask

   function automatic int exp_grant();
      for (int off = 0; off < N; off++) begin
         int j;
         j = (m_ptr + off) % N;
         if (bus.req_valid[j] && (m_tag != j) && (!m_rv[j] || bus.resp_ready[j])) return j;
      end
      return -1;
   endfunction

   task automatic check_model(output int g);
      logic [N-1:0]        er, erv;
      logic [N-1:0][W-1:0] eres;
      g   = exp_grant();
      er  = '0;
      if (g >= 0) er[g] = 1'b1;
      for (int i = 0; i < N; i++) begin
         erv[i]  = m_rv[i];
         eres[i] = m_res[i];
      end
      check("req_ready", bus.req_ready, er);
      check("resp_valid", bus.resp_valid, erv);
      check("resp_result", bus.resp_result, eres);
      check("idle", bus.idle, (m_tag < 0) && (erv == '0));
   endtask

   task automatic model_update(input int g);
      for (int i = 0; i < N; i++)
         if (m_rv[i] && bus.resp_ready[i]) m_rv[i] = 1'b0;
      if (m_tag >= 0) begin
         m_rv[m_tag]  = 1'b1;
         m_res[m_tag] = m_prod;
      end
      if (g >= 0) begin
         m_tag  = g;
         m_prod = qmul(bus.req_a[g], bus.req_b[g]);
         m_ptr  = (g + 1) % N;
      end else begin
         m_tag = -1;
      end
   endtask

   // One clock: check at the falling edge, advance model at the rising edge
   task automatic step();
      int g;
      @(negedge clk);
      check_model(g);
      last_ready = bus.req_ready;
      @(posedge clk);
      model_update(g);
      #1;
   endtask

   initial begin
      logic [N-1:0] prev;
      logic [W-1:0] held;
      bit           found;

      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = '0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_resp_result", bus.resp_result, 0);
      check("rst_idle", bus.idle, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single request: 1.5 * 2.0
      bus.req_valid = 4'b0001;
      bus.req_a[0]  = 32'h0001_8000;
      bus.req_b[0]  = 32'h0002_0000;
      step();
      check("single_grant", last_ready, 4'b0001);
      bus.req_valid = '0;
      check("single_rv_edge1", bus.resp_valid[0], 0);
      step();
      check("single_rv_edge2", bus.resp_valid[0], 1);
      check("single_result", bus.resp_result[0], 32'h0003_0000);
      check("single_idle", bus.idle, 0);
      step();
      check("single_hold", bus.resp_result[0], 32'h0003_0000);
      bus.resp_ready = 4'b0001;
      step();
      check("single_pop", bus.resp_valid[0], 0);
      check("single_idle_after", bus.idle, 1);
      bus.resp_ready = '0;

      // Sign and wrap cases on requesters 1 and 2
      bus.req_valid = 4'b0110;
      bus.req_a[1]  = 32'hFFFF_0000;
      bus.req_b[1]  = 32'h0000_8000;
      bus.req_a[2]  = 32'h7FFF_0000;
      bus.req_b[2]  = 32'h7FFF_0000;
      step();
      step();
      bus.req_valid = '0;
      step();
      step();
      check("sign_result", bus.resp_result[1], 32'hFFFF_8000);
      check("wrap_result", bus.resp_result[2], 32'h0001_0000);
      bus.resp_ready = 4'b1111;
      step();

      // All requesters continuously: one grant per cycle in rotation
      for (int i = 0; i < N; i++) begin
         bus.req_a[i] = $urandom;
         bus.req_b[i] = $urandom;
      end
      bus.req_valid = 4'b1111;
      step();
      prev = last_ready;
      check("rr_first_onehot", $onehot(prev), 1);
      for (int k = 0; k < 8; k++) begin
         step();
         check("rr_order", last_ready, {prev[2:0], prev[3]});
         prev = last_ready;
      end

      // Backpressure on requester 1
      bus.resp_ready = 4'b1101;
      repeat (5) step();
      check("bp_held", bus.resp_valid[1], 1);
      held = bus.resp_result[1];
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_no_grant1", last_ready[1], 0);
         check("bp_others_rotate", last_ready != '0, 1);
         check("bp_stable", bus.resp_result[1], held);
      end
      bus.resp_ready = 4'b1111;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (last_ready[1]) found = 1'b1;
      end
      check("bp_release", found, 1);

      // Pointer wrap with only requesters 3 and 0
      bus.req_valid = 4'b1001;
      step();
      prev = last_ready;
      check("wrap_first", (prev == 4'b1000) || (prev == 4'b0001), 1);
      for (int k = 0; k < 6; k++) begin
         step();
         check("wrap_alt", last_ready, (prev == 4'b1000) ? 4'b0001 : 4'b1000);
         prev = last_ready;
      end

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         bus.req_valid  = N'($urandom);
         bus.resp_ready = N'($urandom) | N'($urandom);
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0:       bus.req_a[i] = 32'h7FFF_0000;
               1:       bus.req_a[i] = 32'h8000_0000;
               default: bus.req_a[i] = $urandom;
            endcase
            bus.req_b[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_0000 : $urandom;
         end
         step();
      end

      // Asynchronous reset one cycle after a grant to requester 2
      bus.req_valid  = '0;
      bus.resp_ready = 4'b1111;
      step();
      step();
      bus.req_valid = 4'b0100;
      step();
      check("mid_grant2", last_ready, 4'b0100);
      bus.req_valid = 4'b1111;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_resp_valid", bus.resp_valid, 0);
      check("mid_rst_req_ready", bus.req_ready, 0);
      check("mid_rst_idle", bus.idle, 1);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = '0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("post_rst_rv2", bus.resp_valid[2], 0);
         check("post_rst_idle", bus.idle, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
